// File: rtl/lift_motion_ctrl.sv
// lift_motion_ctrl -- single-car motion controller with collective dispatch.
//
// The car sits in IDLE for one evaluation cycle at every floor. There it
// decides between opening the door (a request is pending for this floor in
// the current travel direction), moving one floor, or staying put. A move
// lasts TRAVEL_CYCLES cycles and shifts the one-hot floor position on its
// last cycle. A door visit lasts DOOR_CYCLES cycles and is stretched while
// the hold button is pressed.
//
// Ports
//   clk              sole clock, rising edge
//   reset            synchronous, active-high
//   i_up_req_queue   pending hall-up requests, bit k = floor k
//   i_dn_req_queue   pending hall-down requests
//   i_flr_req_queue  pending in-car requests
//   i_door_hold      door-open hold button
//   o_flr_pos        one-hot current floor
//   o_up_clr         one-cycle clear of this floor's hall-up request
//   o_dn_clr         one-cycle clear of this floor's hall-down request
//   o_flr_clr        one-cycle clear of this floor's in-car request
//   o_dir            travel direction, 1 = up, 0 = down
//   o_moving         high while travelling
//   o_door_open      high while the door is open
module lift_motion_ctrl #(
    parameter int N_FLOORS      = 12,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] i_up_req_queue,
    input  logic [N_FLOORS-1:0] i_dn_req_queue,
    input  logic [N_FLOORS-1:0] i_flr_req_queue,
    input  logic                i_door_hold,
    output logic [N_FLOORS-1:0] o_flr_pos,
    output logic                o_up_clr,
    output logic                o_dn_clr,
    output logic                o_flr_clr,
    output logic                o_dir,
    output logic                o_moving,
    output logic                o_door_open
);

    localparam int CMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] TRV_LOAD  = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);
    localparam logic [N_FLOORS-1:0] ONE = {{(N_FLOORS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

    state_t              state_q;
    logic [N_FLOORS-1:0] pos_q;
    logic [CW-1:0]       cnt_q;
    logic                dir_q;
    logic                up_clr_q;
    logic                dn_clr_q;
    logic                flr_clr_q;
    logic                moving_q;
    logic                door_q;

    logic [N_FLOORS-1:0] req_all;
    logic [N_FLOORS-1:0] below_mask;
    logic [N_FLOORS-1:0] above_mask;
    logic                above;
    logic                below;
    logic                hit_up;
    logic                hit_dn;
    logic                hit_flr;

    // With a one-hot position, pos-1 sets exactly the bits below the car.
    // Because the masks only ever cover in-range floors, the car can never
    // be sent up from the top floor or down from the bottom one.
    always_comb begin
        req_all    = i_up_req_queue | i_dn_req_queue | i_flr_req_queue;
        below_mask = pos_q - ONE;
        above_mask = ~(pos_q | below_mask);
        above      = |(req_all & above_mask);
        below      = |(req_all & below_mask);
        hit_up     = |(i_up_req_queue & pos_q);
        hit_dn     = |(i_dn_req_queue & pos_q);
        hit_flr    = |(i_flr_req_queue & pos_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pos_q     <= ONE;
            cnt_q     <= '0;
            dir_q     <= 1'b1;
            up_clr_q  <= 1'b0;
            dn_clr_q  <= 1'b0;
            flr_clr_q <= 1'b0;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            // Strobes are single-cycle: only the IDLE->DOOR transition sets them.
            up_clr_q  <= 1'b0;
            dn_clr_q  <= 1'b0;
            flr_clr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dir_q) begin
                        if (hit_flr || hit_up) begin
                            state_q   <= DOOR;
                            door_q    <= 1'b1;
                            cnt_q     <= DOOR_LOAD;
                            flr_clr_q <= 1'b1;
                            up_clr_q  <= 1'b1;
                        end else if (hit_dn && !above) begin
                            // Nothing further up: turn around and serve the down call here.
                            state_q   <= DOOR;
                            door_q    <= 1'b1;
                            cnt_q     <= DOOR_LOAD;
                            dir_q     <= 1'b0;
                            flr_clr_q <= 1'b1;
                            dn_clr_q  <= 1'b1;
                        end else if (above) begin
                            state_q  <= MOVE_UP;
                            moving_q <= 1'b1;
                            cnt_q    <= TRV_LOAD;
                        end else if (below) begin
                            state_q  <= MOVE_DN;
                            moving_q <= 1'b1;
                            cnt_q    <= TRV_LOAD;
                            dir_q    <= 1'b0;
                        end
                    end else begin
                        if (hit_flr || hit_dn) begin
                            state_q   <= DOOR;
                            door_q    <= 1'b1;
                            cnt_q     <= DOOR_LOAD;
                            flr_clr_q <= 1'b1;
                            dn_clr_q  <= 1'b1;
                        end else if (hit_up && !below) begin
                            state_q   <= DOOR;
                            door_q    <= 1'b1;
                            cnt_q     <= DOOR_LOAD;
                            dir_q     <= 1'b1;
                            flr_clr_q <= 1'b1;
                            up_clr_q  <= 1'b1;
                        end else if (below) begin
                            state_q  <= MOVE_DN;
                            moving_q <= 1'b1;
                            cnt_q    <= TRV_LOAD;
                        end else if (above) begin
                            state_q  <= MOVE_UP;
                            moving_q <= 1'b1;
                            cnt_q    <= TRV_LOAD;
                            dir_q    <= 1'b1;
                        end
                    end
                end
                MOVE_UP: begin
                    if (cnt_q == '0) begin
                        pos_q    <= pos_q << 1;
                        state_q  <= IDLE;
                        moving_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                MOVE_DN: begin
                    if (cnt_q == '0) begin
                        pos_q    <= pos_q >> 1;
                        state_q  <= IDLE;
                        moving_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DOOR: begin
                    // Hold restarts the full dwell; new calls for this floor
                    // are ignored here and picked up by the next IDLE visit.
                    if (i_door_hold) begin
                        cnt_q <= DOOR_LOAD;
                    end else if (cnt_q == '0) begin
                        state_q <= IDLE;
                        door_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_flr_pos   = pos_q;
    assign o_up_clr    = up_clr_q;
    assign o_dn_clr    = dn_clr_q;
    assign o_flr_clr   = flr_clr_q;
    assign o_dir       = dir_q;
    assign o_moving    = moving_q;
    assign o_door_open = door_q;

endmodule

// File: doc/lift_motion_ctrl.md
LIFT_MOTION_CTRL -- requirements
Module: lift_motion_ctrl

Interface
REQ-001 Parameters SHALL be N_FLOORS, default 12, number of floors; TRAVEL_CYCLES, default 4, cycles per floor-to-floor move (>=1); DOOR_CYCLES, default 3, door-open dwell in cycles (>=2).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_up_req_queue  input  N_FLOORS  pending hall-up requests, bit k = floor k.
REQ-005 i_dn_req_queue  input  N_FLOORS  pending hall-down requests.
REQ-006 i_flr_req_queue  input  N_FLOORS  pending in-car floor requests.
REQ-007 i_door_hold  input  1  door-open hold button.
REQ-008 o_flr_pos  output  N_FLOORS  one-hot current car floor; feeds request-handler floor input.
REQ-009 o_up_clr / o_dn_clr / o_flr_clr  output  1 each  one-cycle clear strobes for the current floor's up/down/car requests.
REQ-010 o_dir  output  1  travel direction, 1=up, 0=down.
REQ-011 o_moving  output  1  high in MOVE_UP/MOVE_DN.
REQ-012 o_door_open  output  1  high in DOOR.

Function
REQ-013 FSM states SHALL be IDLE, MOVE_UP, MOVE_DN, DOOR; all outputs registered.
REQ-014 Definitions, f = current floor: R = up|dn|flr queues; above = any R bit > f; below = any R bit < f.
REQ-015 IDLE evaluation with o_dir=1, first match wins: flr[f]|up[f] -> DOOR, clear flr+up; dn[f]&!above -> DOOR, o_dir<=0, clear flr+dn; above -> MOVE_UP; below -> o_dir<=0, MOVE_DN; else stay IDLE.
REQ-016 IDLE evaluation with o_dir=0 SHALL mirror REQ-015 (swap up/dn, above/below, 1/0).
REQ-017 Clear strobes SHALL assert exactly during the first DOOR cycle, with o_flr_pos already equal to the served floor; o_flr_clr SHALL assert on every DOOR entry.
REQ-018 MOVE_UP/MOVE_DN SHALL last exactly TRAVEL_CYCLES cycles; on the last, o_flr_pos shifts one bit toward the travel direction and the FSM returns to IDLE (one evaluation cycle per floor).
REQ-019 Floors passed without a matching request SHALL not open the door (collective: opposite-direction hall calls skipped while requests lie ahead).
REQ-020 DOOR SHALL last DOOR_CYCLES cycles; while i_door_hold=1 the dwell counter reloads; on expiry go to IDLE.
REQ-021 Requests for the current floor arriving during DOOR SHALL be served by reopening after return to IDLE, not by extending the current dwell.
REQ-022 o_flr_pos SHALL never leave floor range; MOVE_UP never entered at floor N_FLOORS-1, MOVE_DN never at floor 0 (guaranteed by REQ-014 masks).
REQ-023 Queue bits SHALL be sampled only in IDLE; changes during MOVE/DOOR take effect at next IDLE.
REQ-024 o_flr_pos SHALL remain one-hot in every cycle.

Reset
REQ-025 With reset=1 at a clk edge: state IDLE, o_flr_pos=1 (floor 0), o_dir=1, counters 0, all strobes/o_moving/o_door_open 0.
REQ-026 Reset SHALL override any state, including mid-move and mid-dwell, with no partial floor shift.

Verification (N_FLOORS=12, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-027 Reset then idle queues -> o_flr_pos=12'h001, o_dir=1, all other outputs 0 indefinitely.
REQ-028 At floor 0 IDLE, i_flr_req_queue=12'h008 seen cycle 0 -> o_moving cycles 1-4, 6-9, 11-14; o_flr_pos 002/004/008; DOOR cycles 16-18; o_flr_clr=o_up_clr=1 cycle 16 only.
REQ-029 At floor 5, dir up, only i_dn_req_queue=12'h020 -> DOOR, o_dir=0, o_dn_clr=1 and o_flr_clr=1 one cycle, o_up_clr=0.
REQ-030 From floor 0, flr req 12'h100 and dn req 12'h010 -> no stop at floor 4 going up; door at floor 8 with up/flr clears; then o_dir=0, travel down; door at 4 with o_dn_clr.
REQ-031 In DOOR, i_door_hold=1 for 10 cycles -> o_door_open stays high throughout and for 3 cycles after release.
REQ-032 reset asserted during cycle 2 of MOVE_UP from floor 3 -> next edge o_flr_pos=12'h001, IDLE, o_moving=0, no strobes.
